// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receiver and transmitter.
// Holds the frame constants, default bit period and FSM state encodings.
package uart_pkg;

   localparam int unsigned c_DATA_BITS   = 8;
   localparam int unsigned c_STOP_BITS   = 1;
   localparam int unsigned c_CPB_DEFAULT = 434;

   typedef enum logic [5:0] {
      S_IDLE      = 6'b000001,
      S_START     = 6'b000010,
      S_DATA      = 6'b000100,
      S_STOP      = 6'b001000,
      S_CLEANUP   = 6'b010000,
      S_WAIT_HIGH = 6'b100000
   } rx_state_e;

endpackage

// File: rtl/uart_sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input.
// Reset value is a parameter so idle-high lines come out of reset idle.
module uart_sync_2ff
   import uart_pkg::*;
#(
   parameter logic c_RST_VAL = 1'b1
) (
   input  logic i_CLK,
   input  logic i_RST_N,
   input  logic i_D,
   output logic o_Q
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture of the asynchronous input
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         meta_q <= c_RST_VAL;
         sync_q <= c_RST_VAL;
      end else begin
         meta_q <= i_D;
         sync_q <= meta_q;
      end
   end

   assign o_Q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit start validation, centre sampling,
// stop-bit check with one-cycle data-valid or framing-error strobe.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned c_CYCLES_PER_BIT = c_CPB_DEFAULT
) (
   input  logic       i_CLK,
   input  logic       i_RST_N,
   input  logic       i_SERIAL_DATA,
   output logic [7:0] o_PARALLEL_DATA,
   output logic       o_RX_DV,
   output logic       o_RX_ACTIVE,
   output logic       o_FRAME_ERR
);

   localparam int unsigned c_CW = $clog2(c_CYCLES_PER_BIT);
   localparam logic [c_CW-1:0] c_LAST = c_CW'(c_CYCLES_PER_BIT - 1);
   localparam logic [c_CW-1:0] c_HALF = c_CW'((c_CYCLES_PER_BIT - 1) / 2);
   localparam logic [2:0] c_LAST_IDX = 3'(c_DATA_BITS - 1);

   logic            rx_s;
   rx_state_e       state_q, state_d;
   logic [c_CW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shreg_q, shreg_d;
   logic [7:0]      data_q, data_d;
   logic            dv_q, dv_d;
   logic            ferr_q, ferr_d;

   uart_sync_2ff #(.c_RST_VAL(1'b1)) u_sync (
      .i_CLK   (i_CLK),
      .i_RST_N (i_RST_N),
      .i_D     (i_SERIAL_DATA),
      .o_Q     (rx_s)
   );

   // State, counters, shift register and output strobes
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         dv_q    <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         dv_q    <= dv_d;
         ferr_q  <= ferr_d;
      end
   end

   // Next-state, bit sampling and strobe generation
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      dv_d    = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (!rx_s) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == c_HALF) begin
               cnt_d   = '0;
               state_d = rx_s ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == c_LAST) begin
               cnt_d          = '0;
               shreg_d[idx_q] = rx_s;
               if (idx_q == c_LAST_IDX) begin
                  idx_d   = '0;
                  state_d = S_STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == c_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  data_d  = shreg_q;
                  dv_d    = 1'b1;
                  state_d = S_CLEANUP;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_CLEANUP: begin
            state_d = S_IDLE;
         end
         S_WAIT_HIGH: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   assign o_PARALLEL_DATA = data_q;
   assign o_RX_DV         = dv_q;
   assign o_FRAME_ERR     = ferr_q;
   assign o_RX_ACTIVE     = (state_q == S_START) ||
                            (state_q == S_DATA)  ||
                            (state_q == S_STOP);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver for the 8N1 serial link. It is the receive-side counterpart of the team's UART transmitter and runs with the same c_CYCLES_PER_BIT setting.
- Synchronises the asynchronous serial input.
- Validates the start bit at mid-bit.
- Samples 8 data bits LSB-first at bit centres.
- Checks the stop bit, then presents the byte with a one-cycle valid strobe.
- Feeds the PONG control and host-command logic.

Parameters:
c_CYCLES_PER_BIT, 434, clock cycles per bit (for example 50 MHz / 115200 baud). Legal minimum is 4.

Ports:
i_CLK  input  1  system clock; all state changes on the rising edge.
i_RST_N  input  1  asynchronous, active-low reset.
i_SERIAL_DATA  input  1  asynchronous serial line; idles high.
o_PARALLEL_DATA  output  8  last correctly received byte.
o_RX_DV  output  1  one-cycle strobe: o_PARALLEL_DATA holds a new valid byte.
o_RX_ACTIVE  output  1  high while a frame is being received (START through STOP).
o_FRAME_ERR  output  1  one-cycle strobe: the stop bit sampled low.

Behaviour:
- Reset (asynchronous assert, synchronous deassert in the system):
  - State = IDLE, counter = 0, bit index = 0.
  - o_PARALLEL_DATA = 0x00, o_RX_DV = 0, o_RX_ACTIVE = 0, o_FRAME_ERR = 0.
  - Synchroniser flops = 1 (line idle).
- Synchroniser:
  - Two flops; rx_s is the second flop.
  - All decisions use rx_s, so there are 2 cycles of input latency.
- Counter width: $clog2(c_CYCLES_PER_BIT) bits.
- Half-bit point HALF = (c_CYCLES_PER_BIT-1)/2, integer division.
- IDLE:
  - Counter = 0, index = 0.
  - If rx_s == 0: go to START and set o_RX_ACTIVE = 1.
- START:
  - Increment the counter until it equals HALF.
  - At HALF, if rx_s == 0: counter = 0, go to DATA.
  - At HALF, if rx_s == 1 (glitch or false start): go to IDLE, o_RX_ACTIVE = 0, no strobes.
- DATA:
  - Increment the counter until it equals c_CYCLES_PER_BIT-1.
  - At that count: shift register[index] = rx_s and counter = 0.
  - If index < 7: index = index + 1.
  - Else: index = 0, go to STOP.
- STOP:
  - Count to c_CYCLES_PER_BIT-1, then sample rx_s.
  - rx_s == 1:
    - o_PARALLEL_DATA = shift register.
    - o_RX_DV = 1 for exactly one cycle, in the cycle after the sample edge.
    - Go to CLEANUP.
  - rx_s == 0:
    - o_PARALLEL_DATA is unchanged.
    - o_FRAME_ERR = 1 for one cycle.
    - Go to WAIT_HIGH.
- CLEANUP:
  - One cycle; o_RX_ACTIVE = 0, o_RX_DV returns to 0.
  - Then go to IDLE.
- WAIT_HIGH:
  - o_RX_ACTIVE = 0.
  - Stay until rx_s == 1, then go to IDLE.
  - This prevents a break condition (line held low) from retriggering continuous frames.
- Strobe exclusivity: o_RX_DV and o_FRAME_ERR are never high together.
- Byte-to-byte: a new start edge is accepted from IDLE, at the earliest 1 cycle after CLEANUP. Back-to-back frames with a 1-bit stop must therefore be received without loss.
- Reset mid-frame: immediate return to the reset values above; the partial byte is discarded and no strobe is issued.
- Undefined state encoding: go to IDLE.

Decomposition:
- Package uart_pkg holds:
  - State encodings: IDLE, START, DATA, STOP, CLEANUP, WAIT_HIGH (one-hot, 6 bits).
  - The 8N1 constants: data bits = 8, stop bits = 1.
  - The default c_CYCLES_PER_BIT.
  - The package is shared with the transmitter.
- Sub-module uart_sync_2ff:
  - Generic two-flop synchroniser.
  - Parameterised reset value; uses i_CLK / i_RST_N.

Test Plan:
- c_CYCLES_PER_BIT = 8, frame 0xA5 (bits LSB-first 1,0,1,0,0,1,0,1, stop = 1) -> one o_RX_DV pulse; o_PARALLEL_DATA = 0xA5; o_FRAME_ERR never high; o_RX_ACTIVE high from start detection until CLEANUP.
- Low glitch of 2 cycles on an idle line (CPB = 8) -> return to IDLE after the mid-start sample; no o_RX_DV, no o_FRAME_ERR; o_PARALLEL_DATA unchanged.
- Frame 0x3C with the stop bit driven low, then the line held low for 40 cycles, then released -> single o_FRAME_ERR pulse; o_PARALLEL_DATA keeps its previous value; no retrigger until the line is high; a following 0x55 frame is received correctly.
- Back-to-back frames 0x00, 0xFF, 0x81 with no idle gap -> exactly three o_RX_DV pulses, bytes in order.
- Assert i_RST_N low during DATA bit 4 of 0x7E -> all outputs at reset values asynchronously; after release, the next 0x12 frame is received correctly.
- CPB = 434, frame 0xC3 at nominal rate and again with bit period ±3% (421 and 447 cycles) -> 0xC3 received with no error in all three cases.
